mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single halfword-wide memory port between the instruction-fetch requester and the data (load/store) requester. It arbitrates between them, splits 32-bit data accesses into two halfword beats, generates byte-lane write enables, and returns read data with a fixed latency. It sits between the core's IF/EX stages and the external `i_mem_do`/`o_mem_*` port and replaces the direct address/memory controller hookup.

## Interface
- `MEM_DEPTH`, default 2**12: memory size in halfwords.
- `STARVE_LIMIT`, default 4: number of consecutive denied fetch cycles after which fetch is forced to win.
- `ADDR_WIDTH` (localparam) = `$clog2(MEM_DEPTH*2)`: byte address width.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `i_if_req` in, 1: fetch request; held until granted.
- `i_if_addr` in, ADDR_WIDTH: fetch byte address; bit 0 is ignored (forced to 0).
- `o_if_gnt` out, 1: fetch issued to memory this cycle.
- `o_if_valid` out, 1: `o_if_data` is valid.
- `o_if_data` out, 16: fetched halfword.
- `i_d_req` in, 1: data request; held, with all `i_d_*` stable, until granted.
- `i_d_we` in, 1: 1 = store, 0 = load.
- `i_d_size` in, 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as misaligned.
- `i_d_addr` in, ADDR_WIDTH: data byte address.
- `i_d_wdata` in, 32: store data, right-aligned for byte and halfword accesses.
- `o_d_gnt` out, 1: data request accepted this cycle.
- `o_d_valid` out, 1: data access complete; `o_d_rdata` is valid for loads.
- `o_d_rdata` out, 32: load data, zero-extended for byte and halfword accesses.
- `o_d_err` out, 1: misaligned or illegal access; qualified by `o_d_valid`.
- `i_mem_do` in, [0:1][7:0]: memory read data. Lane 0 is the even byte and lane 1 the odd byte; the halfword value is {lane0, lane1}.
- `o_mem_addr` out, ADDR_WIDTH: memory byte address; bit 0 is always 0.
- `o_mem_di` out, [0:1][7:0]: memory write data.
- `o_mem_en` out, 1: equals `o_mem_rd_en | (|o_mem_wr_en)`.
- `o_mem_rd_en` out, 1: read strobe.
- `o_mem_wr_en` out, [0:1]: per-lane write strobes.

## Operation
- The memory is synchronous: a read issued in cycle T returns on `i_mem_do` in T+1. A write commits in its issue cycle.
- Memory-side outputs and grants are combinational from the current state and the requests. Other state is registered.
- **States**
  - IDLE: port free.
  - D_RD2: second beat of a word load.
  - D_WR2: second beat of a word store.
- **Arbitration in IDLE**
  - Data has priority over fetch.
  - Exception: when `starve_cnt == STARVE_LIMIT` and `i_if_req` is high, fetch wins.
- **starve_cnt**
  - Increments each cycle that `i_if_req` is high and `o_if_gnt` is low, saturating at `STARVE_LIMIT`.
  - Clears on a fetch grant or when `i_if_req` is low.
- **D_RD2 / D_WR2**
  - No grants are issued.
  - The second beat goes to address A+2; the next state is IDLE.
- **Word ordering** (big-endian): the word is {hw(A), hw(A+2)}.
  - Beat 1 reads or writes bits [31:16].
  - Beat 2 reads or writes bits [15:0].
  - Beat-1 read data is captured into an internal register in D_RD2.
- **Byte access**
  - The halfword address is A with bit 0 cleared.
  - A even selects lane 0; A odd selects lane 1.
  - Writes replicate `wdata[7:0]` on both lanes and strobe only the selected lane.
  - Reads return {24'b0, selected lane}.
- **Halfword access**: both lanes are used; reads return {16'b0, hw}.
- **Misaligned access** (halfword with A[0]=1, word with A[1:0]≠0, or size 11):
  - The request is granted with no memory access.
  - In the next cycle: `o_d_valid` = 1, `o_d_err` = 1, `o_d_rdata` = 0.
- **Reset**: `rst` wins over everything. An in-progress word access is aborted: no second beat and no valid is produced.
- **Reset values**
  - All outputs are 0, including the combinational ones, because requests are ignored while `rst` is high.
  - State returns to IDLE; `starve_cnt` and the capture register are cleared.

## Timing
- Fetch: grant at T, `o_if_valid` at T+1. Back-to-back fetches sustain one per cycle.
- Byte/halfword load: grant at T, `o_d_valid` at T+1.
- Byte/halfword store: grant at T, write at T, `o_d_valid` at T+1 (acknowledge).
- Word load: grant at T (beat A), beat A+2 at T+1, `o_d_valid` at T+2.
- Word store: grant at T, writes at T and T+1, `o_d_valid` at T+2.
- Pipelining: a new grant may coincide with the valid cycle of the previous access. In particular, at T+1 of a single-beat access the port is free.
- `o_if_valid` and `o_d_valid` are one-cycle pulses and are never high in the same cycle.
- Requests arriving during D_RD2 or D_WR2 wait; the earliest grant is T+2.

## Test plan
- **Single fetch after reset**: `i_if_req` held with addr 0x0010 and memory[0x10] = {0x12, 0x34}.
  - `o_if_gnt` at T; `o_if_valid` at T+1 with `o_if_data` = 0x1234; `o_mem_addr` = 0x10.
- **Word load**: addr 0x0020, memory = 0xAABB at 0x20 and 0xCCDD at 0x22.
  - Reads at T and T+1; `o_d_valid` at T+2 with `o_d_rdata` = 0xAABBCCDD.
  - A fetch request held concurrently is not granted before T+2.
- **Byte store**: addr 0x0031, wdata 0x5A.
  - `o_mem_addr` = 0x30, `o_mem_wr_en` = 2'b01, lane 1 = 0x5A; the lane-0 byte is unchanged on readback.
- **Misaligned word load**: addr 0x0042.
  - No `o_mem_en`; `o_d_valid` and `o_d_err` at T+1; `o_d_rdata` = 0.
- **Starvation**: both requesters held continuously with halfword loads.
  - Data is granted 4 cycles, then fetch is granted in cycle 5; the pattern repeats.
- **Reset mid-operation**: `rst` asserted in the D_WR2 cycle of a word store.
  - No second write strobe; no `o_d_valid`; all outputs are 0; IDLE on release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one halfword memory port between instruction fetch and
//               load/store, splitting word accesses into two beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int  MEM_DEPTH    = 2**12,
    parameter int  STARVE_LIMIT = 4,
    localparam int ADDR_WIDTH   = $clog2(MEM_DEPTH*2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_valid,
    output logic [15:0]           o_if_data,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [1:0]            i_d_size,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [31:0]           i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_valid,
    output logic [31:0]           o_d_rdata,
    output logic                  o_d_err,
    input  logic [0:1][7:0]       i_mem_do,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [0:1][7:0]       o_mem_di,
    output logic                  o_mem_en,
    output logic                  o_mem_rd_en,
    output logic [0:1]            o_mem_wr_en
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    // Kind of read data returned in the valid cycle
    localparam logic [1:0] c_rk_none = 2'd0;
    localparam logic [1:0] c_rk_byte = 2'd1;
    localparam logic [1:0] c_rk_half = 2'd2;
    localparam logic [1:0] c_rk_word = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_D_RD2 = 2'd1,
        ST_D_WR2 = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic [ADDR_WIDTH-1:0] r_addr2, w_addr2_nxt;
    logic [15:0]           r_wdata_lo, w_wdata_lo_nxt;
    logic [15:0]           r_hi;
    logic                  r_if_valid, w_if_valid_nxt;
    logic                  r_d_valid, w_d_valid_nxt;
    logic                  r_d_err, w_d_err_nxt;
    logic [1:0]            r_rd_kind, w_rd_kind_nxt;
    logic                  r_rd_lane, w_rd_lane_nxt;

    logic                  w_if_gnt;
    logic                  w_misaligned;
    logic                  w_fetch_wins;

    assign w_misaligned = (i_d_size == 2'b11)
                        | ((i_d_size == 2'b01) & i_d_addr[0])
                        | ((i_d_size == 2'b10) & (|i_d_addr[1:0]));
    assign w_fetch_wins = i_if_req & (~i_d_req | (r_starve_cnt == CNT_W'(STARVE_LIMIT)));

    always_comb begin
        w_state_nxt    = r_state;
        w_addr2_nxt    = r_addr2;
        w_wdata_lo_nxt = r_wdata_lo;
        w_if_valid_nxt = 1'b0;
        w_d_valid_nxt  = 1'b0;
        w_d_err_nxt    = 1'b0;
        w_rd_kind_nxt  = c_rk_none;
        w_rd_lane_nxt  = 1'b0;
        w_if_gnt       = 1'b0;
        o_d_gnt        = 1'b0;
        o_mem_addr     = '0;
        o_mem_di       = '0;
        o_mem_rd_en    = 1'b0;
        o_mem_wr_en    = 2'b00;
        // Requests are ignored entirely while reset is asserted
        if (!rst) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fetch_wins) begin
                        w_if_gnt       = 1'b1;
                        o_mem_addr     = {i_if_addr[ADDR_WIDTH-1:1], 1'b0};
                        o_mem_rd_en    = 1'b1;
                        w_if_valid_nxt = 1'b1;
                    end else if (i_d_req) begin
                        o_d_gnt       = 1'b1;
                        w_d_valid_nxt = 1'b1;
                        if (w_misaligned) begin
                            w_d_err_nxt = 1'b1;
                        end else begin
                            o_mem_addr = {i_d_addr[ADDR_WIDTH-1:1], 1'b0};
                            unique case (i_d_size)
                                2'b00: begin
                                    o_mem_di      = {i_d_wdata[7:0], i_d_wdata[7:0]};
                                    w_rd_lane_nxt = i_d_addr[0];
                                    if (i_d_we) begin
                                        o_mem_wr_en = i_d_addr[0] ? 2'b01 : 2'b10;
                                    end else begin
                                        o_mem_rd_en   = 1'b1;
                                        w_rd_kind_nxt = c_rk_byte;
                                    end
                                end
                                2'b01: begin
                                    o_mem_di = i_d_wdata[15:0];
                                    if (i_d_we) begin
                                        o_mem_wr_en = 2'b11;
                                    end else begin
                                        o_mem_rd_en   = 1'b1;
                                        w_rd_kind_nxt = c_rk_half;
                                    end
                                end
                                default: begin
                                    // Word: high half now, low half from A+2 next cycle
                                    w_d_valid_nxt  = 1'b0;
                                    o_mem_di       = i_d_wdata[31:16];
                                    w_addr2_nxt    = i_d_addr + ADDR_WIDTH'(2);
                                    w_wdata_lo_nxt = i_d_wdata[15:0];
                                    if (i_d_we) begin
                                        o_mem_wr_en = 2'b11;
                                        w_state_nxt = ST_D_WR2;
                                    end else begin
                                        o_mem_rd_en = 1'b1;
                                        w_state_nxt = ST_D_RD2;
                                    end
                                end
                            endcase
                        end
                    end
                end
                ST_D_RD2: begin
                    o_mem_addr    = r_addr2;
                    o_mem_rd_en   = 1'b1;
                    w_d_valid_nxt = 1'b1;
                    w_rd_kind_nxt = c_rk_word;
                    w_state_nxt   = ST_IDLE;
                end
                ST_D_WR2: begin
                    o_mem_addr    = r_addr2;
                    o_mem_di      = r_wdata_lo;
                    o_mem_wr_en   = 2'b11;
                    w_d_valid_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_addr2      <= '0;
            r_wdata_lo   <= '0;
            r_hi         <= '0;
            r_if_valid   <= 1'b0;
            r_d_valid    <= 1'b0;
            r_d_err      <= 1'b0;
            r_rd_kind    <= c_rk_none;
            r_rd_lane    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr2    <= w_addr2_nxt;
            r_wdata_lo <= w_wdata_lo_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_d_valid  <= w_d_valid_nxt;
            r_d_err    <= w_d_err_nxt;
            r_rd_kind  <= w_rd_kind_nxt;
            r_rd_lane  <= w_rd_lane_nxt;
            if (r_state == ST_D_RD2) begin
                r_hi <= i_mem_do;
            end
            if (i_if_req && !w_if_gnt) begin
                if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_mem_en    = o_mem_rd_en | (|o_mem_wr_en);
    assign o_if_valid  = r_if_valid & ~rst;
    assign o_if_data   = o_if_valid ? i_mem_do : 16'h0000;
    assign o_d_valid   = r_d_valid & ~rst;
    assign o_d_err     = o_d_valid & r_d_err;

    always_comb begin
        o_d_rdata = 32'h0000_0000;
        if (o_d_valid) begin
            unique case (r_rd_kind)
                c_rk_byte: o_d_rdata = {24'h000000, i_mem_do[r_rd_lane]};
                c_rk_half: o_d_rdata = {16'h0000, i_mem_do};
                c_rk_word: o_d_rdata = {r_hi, i_mem_do};
                default:   o_d_rdata = 32'h0000_0000;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter with a byte-lane memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 13;
    localparam int NV = 18;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt, if_valid;
    logic [15:0]     if_data;
    logic            d_req, d_we;
    logic [1:0]      d_size;
    logic [AW-1:0]   d_addr;
    logic [31:0]     d_wdata;
    logic            d_gnt, d_valid, d_err;
    logic [31:0]     d_rdata;
    logic [0:1][7:0] mem_do;
    logic [AW-1:0]   mem_addr;
    logic [0:1][7:0] mem_di;
    logic            mem_en, mem_rd_en;
    logic [0:1]      mem_wr_en;

    logic [7:0]      mem [0:8191];
    logic            init_mem;
    int              checks = 0;
    int              errors = 0;

    mem_port_arbiter #(.MEM_DEPTH(4096), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_valid(if_valid), .o_if_data(if_data),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_valid(d_valid),
        .o_d_rdata(d_rdata), .o_d_err(d_err),
        .i_mem_do(mem_do), .o_mem_addr(mem_addr), .o_mem_di(mem_di),
        .o_mem_en(mem_en), .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data one cycle later, writes commit at the edge
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem[13'h010] <= 8'h12; mem[13'h011] <= 8'h34;
            mem[13'h020] <= 8'hAA; mem[13'h021] <= 8'hBB;
            mem[13'h022] <= 8'hCC; mem[13'h023] <= 8'hDD;
            mem[13'h030] <= 8'h77; mem[13'h031] <= 8'h66;
            mem[13'h04A] <= 8'h55; mem[13'h04B] <= 8'h66;
            mem[13'h060] <= 8'h01; mem[13'h061] <= 8'h02;
            mem[13'h062] <= 8'h03; mem[13'h063] <= 8'h04;
            mem_do <= '0;
        end else begin
            if (mem_rd_en) mem_do <= {mem[mem_addr], mem[mem_addr | 13'd1]};
            if (mem_wr_en[0]) mem[mem_addr] <= mem_di[0];
            if (mem_wr_en[1]) mem[mem_addr | 13'd1] <= mem_di[1];
        end
    end

    typedef struct {
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [12:0] exp_maddr;
        logic [1:0]  exp_wen;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        word;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_di(input vec_t v);
        case (v.size)
            2'b00:   return {v.wdata[7:0], v.wdata[7:0]};
            2'b01:   return v.wdata[15:0];
            default: return v.wdata[31:16];
        endcase
    endfunction

    function automatic logic [127:0] all_outs();
        return {if_gnt, if_valid, if_data, d_gnt, d_valid, d_rdata, d_err,
                mem_addr, mem_di, mem_en, mem_rd_en, mem_wr_en};
    endfunction

    initial begin
        //          fetch we  size   addr     wdata          maddr    wen    err   rdata          word
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 13'h010, 32'h0,         13'h010, 2'b00, 1'b0, 32'h0000_1234, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 13'h023, 32'h0,         13'h022, 2'b00, 1'b0, 32'h0000_CCDD, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'b10, 13'h020, 32'h0,         13'h020, 2'b00, 1'b0, 32'hAABB_CCDD, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 13'h021, 32'h0,         13'h020, 2'b00, 1'b0, 32'h0000_00BB, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 13'h020, 32'h0,         13'h020, 2'b00, 1'b0, 32'h0000_00AA, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 13'h022, 32'h0,         13'h022, 2'b00, 1'b0, 32'h0000_CCDD, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 13'h031, 32'h0000_005A, 13'h030, 2'b01, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 13'h030, 32'h0,         13'h030, 2'b00, 1'b0, 32'h0000_0077, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 13'h031, 32'h0,         13'h030, 2'b00, 1'b0, 32'h0000_005A, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 13'h040, 32'h0000_BEEF, 13'h040, 2'b11, 1'b0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b01, 13'h040, 32'h0,         13'h040, 2'b00, 1'b0, 32'h0000_BEEF, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b10, 13'h044, 32'h1122_3344, 13'h044, 2'b11, 1'b0, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 1'b0, 2'b10, 13'h044, 32'h0,         13'h044, 2'b00, 1'b0, 32'h1122_3344, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'b10, 13'h042, 32'h0,         13'h000, 2'b00, 1'b1, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 1'b0, 2'b01, 13'h023, 32'h0,         13'h000, 2'b00, 1'b1, 32'h0,         1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'b11, 13'h060, 32'h0,         13'h000, 2'b00, 1'b1, 32'h0,         1'b0};
        vecs[16] = '{1'b0, 1'b1, 2'b10, 13'h062, 32'hFFFF_FFFF, 13'h000, 2'b00, 1'b1, 32'h0,         1'b0};
        vecs[17] = '{1'b0, 1'b0, 2'b10, 13'h060, 32'h0,         13'h060, 2'b00, 1'b0, 32'h0102_0304, 1'b1};

        // Reset with both requesters active: every output must stay 0
        init_mem = 1'b1;
        rst      = 1'b1;
        if_req = 1'b1; if_addr = 13'h010;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 13'h040; d_wdata = 32'h1234;
        tick; tick;
        chk("reset_outputs", all_outs(), '0);
        init_mem = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk("post_reset_idle", all_outs(), '0);

        for (int k = 0; k < NV; k++) begin
            vec_t v;
            v = vecs[k];
            if (v.fetch) begin
                if_req = 1'b1; if_addr = v.addr;
            end else begin
                d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
            end
            #1;
            chk($sformatf("v%0d_gnt", k), v.fetch ? if_gnt : d_gnt, 1'b1);
            chk($sformatf("v%0d_other_gnt", k), v.fetch ? d_gnt : if_gnt, 1'b0);
            chk($sformatf("v%0d_mem_addr", k), mem_addr, v.exp_maddr);
            chk($sformatf("v%0d_wr_en", k), mem_wr_en, v.exp_wen);
            chk($sformatf("v%0d_rd_en", k), mem_rd_en, !v.exp_err && !v.we);
            chk($sformatf("v%0d_mem_en", k), mem_en, !v.exp_err);
            if (v.exp_wen != 2'b00) chk($sformatf("v%0d_mem_di", k), mem_di, exp_di(v));
            tick;
            if_req = 1'b0; d_req = 1'b0;
            #1;
            if (v.word) begin
                chk($sformatf("v%0d_beat2_valid", k), {if_valid, d_valid, d_gnt, if_gnt}, 4'b0000);
                chk($sformatf("v%0d_beat2_addr", k), mem_addr, v.exp_maddr + 13'd2);
                chk($sformatf("v%0d_beat2_wr_en", k), mem_wr_en, v.we ? 2'b11 : 2'b00);
                chk($sformatf("v%0d_beat2_rd_en", k), mem_rd_en, !v.we);
                if (v.we) chk($sformatf("v%0d_beat2_di", k), mem_di, v.wdata[15:0]);
                tick;
            end
            if (v.fetch) begin
                chk($sformatf("v%0d_if_valid", k), {if_valid, d_valid}, 2'b10);
                chk($sformatf("v%0d_if_data", k), if_data, v.exp_rdata[15:0]);
            end else begin
                chk($sformatf("v%0d_d_valid", k), {d_valid, if_valid}, 2'b10);
                chk($sformatf("v%0d_d_err", k), d_err, v.exp_err);
                chk($sformatf("v%0d_d_rdata", k), d_rdata, v.exp_rdata);
            end
        end
        tick;

        // Word load with a fetch waiting: fetch gets the port only at T+2
        if_req = 1'b1; if_addr = 13'h010;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 13'h020;
        #1;
        chk("wl_gnt_t0", {d_gnt, if_gnt}, 2'b10);
        tick;
        d_req = 1'b0;
        chk("wl_gnt_t1", {d_gnt, if_gnt}, 2'b00);
        chk("wl_addr_t1", mem_addr, 13'h022);
        tick;
        chk("wl_valid_t2", {d_valid, if_gnt}, 2'b11);
        chk("wl_rdata_t2", d_rdata, 32'hAABB_CCDD);
        chk("wl_fetch_addr_t2", mem_addr, 13'h010);
        tick;
        if_req = 1'b0;
        chk("wl_if_data_t3", {if_valid, if_data}, {1'b1, 16'h1234});
        tick;

        // Starvation: four data grants, then fetch, repeating
        begin
            logic prev_d, prev_f, exp_d;
            prev_d = 1'b0; prev_f = 1'b0;
            if_req = 1'b1; if_addr = 13'h010;
            d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 13'h022;
            for (int c = 0; c < 10; c++) begin
                #1;
                exp_d = (c % 5) != 4;
                chk($sformatf("starve_c%0d_gnt", c), {d_gnt, if_gnt}, {exp_d, !exp_d});
                chk($sformatf("starve_c%0d_valid", c), {d_valid, if_valid}, {prev_d, prev_f});
                if (prev_d) chk($sformatf("starve_c%0d_rdata", c), d_rdata, 32'h0000_CCDD);
                if (prev_f) chk($sformatf("starve_c%0d_if_data", c), if_data, 16'h1234);
                prev_d = exp_d; prev_f = !exp_d;
                @(posedge clk);
            end
            #1;
            if_req = 1'b0; d_req = 1'b0;
            tick; tick;
        end

        // Reset in the second beat of a word store aborts it
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 13'h048; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_ws_gnt", d_gnt, 1'b1);
        tick;
        d_req = 1'b0; d_we = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ws_outputs", all_outs(), '0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst_ws_no_valid", all_outs(), '0);
        d_req = 1'b1; d_size = 2'b01; d_addr = 13'h04A;
        #1;
        chk("rst_ws_idle_gnt", d_gnt, 1'b1);
        tick;
        d_addr = 13'h048;
        chk("rst_ws_no_beat2", d_rdata, 32'h0000_5566);
        #1;
        tick;
        d_req = 1'b0;
        chk("rst_ws_beat1", d_rdata, 32'h0000_DEAD);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
